// File: rtl/pulse_trigger_receiver_multi_if.sv
// Bus bundle for the multi-channel pulse trigger receiver: TTC controls,
// trigger levels/pulses, status and the 128-bit record FIFO handshake.
interface pulse_trigger_receiver_multi_if #(
  parameter int NUM_CH = 4
);
  logic              reset_trig_num;
  logic              reset_trig_timestamp;
  logic              readout_done;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] trigger;
  logic [NUM_CH-1:0] pulse_trigger;
  logic              fifo_ready;
  logic              fifo_valid;
  logic [127:0]      fifo_data;
  logic [NUM_CH-1:0] busy;
  logic [15:0]       missed_cnt;

  modport master (
    output reset_trig_num, reset_trig_timestamp, readout_done,
    output ch_enable, trigger, fifo_ready,
    input  pulse_trigger, fifo_valid, fifo_data, busy, missed_cnt
  );

  modport slave (
    input  reset_trig_num, reset_trig_timestamp, readout_done,
    input  ch_enable, trigger, fifo_ready,
    output pulse_trigger, fifo_valid, fifo_data, busy, missed_cnt
  );
endinterface

// File: rtl/pulse_trigger_receiver_multi.sv
// Multi-channel front-panel trigger receiver: edge detect, pulse-length
// classification, trigger numbering/timestamping and round-robin record output.
//
// state   | meaning
// IDLE    | waiting for an enabled rising edge
// SEND    | one-cycle pulse_trigger, first window sample after the edge
// WINDOW  | sampling trigger level until WIN_LEN samples taken
// PENDING | record ready, waiting for the output arbiter
// DEAD    | hold-off for DEAD_CYC cycles after the record is granted
module pulse_trigger_receiver_multi #(
  parameter int NUM_CH    = 4,
  parameter int WIN_LEN   = 4,
  parameter int SHORT_MAX = 1,
  parameter int DEAD_CYC  = 2
) (
  input logic                          clk,
  input logic                          reset_n,
  pulse_trigger_receiver_multi_if.slave bus
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_SEND    = 5'b00010,
    S_WINDOW  = 5'b00100,
    S_PENDING = 5'b01000,
    S_DEAD    = 5'b10000
  } ch_state_t;

  localparam logic [3:0] WIN_LEN4   = 4'(WIN_LEN);
  localparam logic [3:0] SHORT_MAX4 = 4'(SHORT_MAX);

  ch_state_t         state    [NUM_CH];
  logic [3:0]        hi_cnt   [NUM_CH];
  logic [3:0]        win_cnt  [NUM_CH];
  logic [7:0]        dead_cnt [NUM_CH];
  logic [1:0]        typ      [NUM_CH];
  logic [43:0]       ts_lat   [NUM_CH];
  logic [23:0]       num_lat  [NUM_CH];
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] trig_d;
  logic [NUM_CH-1:0] pulse_q;
  logic [43:0]       ts_cnt;
  logic [23:0]       trig_num;
  logic [15:0]       missed_q;
  logic [3:0]        last_gnt;
  logic              fifo_valid_q;
  logic [127:0]      fifo_data_q;

  logic [NUM_CH-1:0] edge_v, idle_v, accept, ignored, pend, grant_vec;
  logic [3:0]        hi_nx    [NUM_CH];
  logic [1:0]        cls      [NUM_CH];
  logic [23:0]       num_asg  [NUM_CH];
  logic [23:0]       num_run, trig_num_nx;
  logic [4:0]        miss_add;
  logic [16:0]       miss_sum;
  logic [15:0]       missed_nx;
  logic              load_en, gnt_found;
  logic [3:0]        gnt_idx;
  logic [127:0]      record;

  always_comb begin
    edge_v = bus.trigger & ~trig_d;
    for (int c = 0; c < NUM_CH; c++) begin
      idle_v[c] = (state[c] == S_IDLE);
      pend[c]   = (state[c] == S_PENDING);
      hi_nx[c]  = (run[c] & bus.trigger[c]) ? hi_cnt[c] + 4'd1 : hi_cnt[c];
      if (hi_nx[c] <= SHORT_MAX4)     cls[c] = 2'b10;
      else if (hi_nx[c] == WIN_LEN4)  cls[c] = 2'b01;
      else                            cls[c] = 2'b11;
    end
    accept  = edge_v & bus.ch_enable & idle_v;
    ignored = edge_v & bus.ch_enable & ~idle_v;
  end

  // Same-cycle accepts are numbered in ascending channel order; a clear restarts at 1.
  always_comb begin
    num_run = (bus.reset_trig_num | bus.readout_done) ? 24'd0 : trig_num;
    for (int c = 0; c < NUM_CH; c++) begin
      num_asg[c] = '0;
      if (accept[c]) begin
        num_run    = num_run + 24'd1;
        num_asg[c] = num_run;
      end
    end
    trig_num_nx = num_run;
  end

  always_comb begin
    miss_add = '0;
    for (int c = 0; c < NUM_CH; c++) miss_add = miss_add + {4'd0, ignored[c]};
    miss_sum  = {1'b0, missed_q} + {12'd0, miss_add};
    missed_nx = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
  end

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    load_en   = ~fifo_valid_q | bus.fifo_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    record    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!gnt_found && pend[(int'(last_gnt) + i) % NUM_CH]) begin
        gnt_found = 1'b1;
        gnt_idx   = 4'((int'(last_gnt) + i) % NUM_CH);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      grant_vec[c] = load_en & gnt_found & (gnt_idx == 4'(c));
      if (gnt_found && gnt_idx == 4'(c))
        record = {54'd0, 4'(c), typ[c], num_lat[c], ts_lat[c]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]    <= S_IDLE;
        hi_cnt[c]   <= '0;
        win_cnt[c]  <= '0;
        dead_cnt[c] <= '0;
        typ[c]      <= '0;
        ts_lat[c]   <= '0;
        num_lat[c]  <= '0;
      end
      run          <= '0;
      trig_d       <= '0;
      pulse_q      <= '0;
      ts_cnt       <= '0;
      trig_num     <= '0;
      missed_q     <= '0;
      last_gnt     <= 4'(NUM_CH - 1);
      fifo_valid_q <= 1'b0;
      fifo_data_q  <= '0;
    end else begin
      trig_d   <= bus.trigger;
      pulse_q  <= accept;
      ts_cnt   <= bus.reset_trig_timestamp ? 44'd0 : ts_cnt + 44'd1;
      trig_num <= trig_num_nx;
      missed_q <= missed_nx;

      for (int c = 0; c < NUM_CH; c++) begin
        case (state[c])
          S_IDLE: begin
            if (accept[c]) begin
              ts_lat[c]  <= ts_cnt;
              num_lat[c] <= num_asg[c];
              hi_cnt[c]  <= 4'd1;
              run[c]     <= 1'b1;
              win_cnt[c] <= WIN_LEN4 - 4'd1;
              state[c]   <= S_SEND;
            end
          end
          S_SEND, S_WINDOW: begin
            hi_cnt[c]  <= hi_nx[c];
            run[c]     <= run[c] & bus.trigger[c];
            win_cnt[c] <= win_cnt[c] - 4'd1;
            if (win_cnt[c] == 4'd1) begin
              typ[c]   <= cls[c];
              state[c] <= S_PENDING;
            end else begin
              state[c] <= S_WINDOW;
            end
          end
          S_PENDING: begin
            if (grant_vec[c]) begin
              dead_cnt[c] <= 8'(DEAD_CYC);
              state[c]    <= (DEAD_CYC == 0) ? S_IDLE : S_DEAD;
            end
          end
          S_DEAD: begin
            if (dead_cnt[c] == 8'd1) state[c] <= S_IDLE;
            else                     dead_cnt[c] <= dead_cnt[c] - 8'd1;
          end
          default: state[c] <= S_IDLE;
        endcase
      end

      if (load_en) begin
        fifo_valid_q <= gnt_found;
        fifo_data_q  <= record;
        if (gnt_found) last_gnt <= gnt_idx;
      end
    end
  end

  assign bus.pulse_trigger = pulse_q;
  assign bus.fifo_valid    = fifo_valid_q;
  assign bus.fifo_data     = fifo_data_q;
  assign bus.busy          = ~idle_v;
  assign bus.missed_cnt    = missed_q;

endmodule
